// File: rtl/exec_result_buffer.sv
// Per-execution-unit result queue feeding the execute-output arbiter.
// Holds {value, commands, tag, flags} until the arbiter grants via canGo_i,
// and back-pressures the unit through ready_o when all entries are occupied.
// Outputs depend on registered state only; a result pushed at one edge is
// visible on the outputs after that edge (no same-cycle bypass).
// Optional feature: define EXEC_BUF_FLUSH_EN to add flush_i, which clears the
// queue like reset_i (used on branch mispredict).
module exec_result_buffer #(
  parameter int unsigned ROBsize    = 8,
  parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTHLog   = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef EXEC_BUF_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  valid_i,
  input  logic [63:0]           val_i,
  input  logic [9:0]            commands_i,
  input  logic [ROBsizeLog-1:0] tag_i,
  input  logic [3:0]            flags_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [63:0]           val_o,
  output logic [9:0]            commands_o,
  output logic [ROBsizeLog-1:0] tag_o,
  output logic [3:0]            flags_o,
  input  logic                  canGo_i,
  output logic [DEPTHLog:0]     count_o
);

  localparam int unsigned EntryW = 64 + 10 + ROBsizeLog + 4;
  localparam logic [DEPTHLog:0] CountFull = (DEPTHLog + 1)'(DEPTH);

  logic [EntryW-1:0]   mem_q [DEPTH];
  logic [DEPTHLog-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTHLog-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTHLog:0]   count_q, count_d;
  logic                push, pop, clear;
  logic [EntryW-1:0]   head;

`ifdef EXEC_BUF_FLUSH_EN
  assign clear = reset_i | flush_i;
`else
  assign clear = reset_i;
`endif

  // Handshakes come from registered occupancy only, so no comb path crosses the buffer.
  always_comb begin
    ready_o = (count_q != CountFull);
    valid_o = (count_q != '0);
    push    = valid_i & ready_o;
    pop     = canGo_i & valid_o;
  end

  // Next-state for pointers and occupancy; clear overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow wraps DEPTH-1 -> 0.
      if (push) wr_ptr_d = wr_ptr_q + DEPTHLog'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTHLog'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (DEPTHLog + 1)'(1);
        2'b01:   count_d = count_q - (DEPTHLog + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not cleared; stale contents are masked by valid_o.
  always_ff @(posedge clk_i) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= {val_i, commands_i, tag_i, flags_i};
    end
  end

  // Head entry is presented only while valid, otherwise all-zero data.
  always_comb begin
    head = valid_o ? mem_q[rd_ptr_q] : '0;
    {val_o, commands_o, tag_o, flags_o} = head;
    count_o = count_q;
  end

endmodule

// File: tb/tb_exec_result_buffer.sv
// Self-checking bench for exec_result_buffer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a queue model.
module tb_exec_result_buffer;

  localparam int unsigned ROBsizeLog = 4;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DEPTHLog   = 2;

  logic                  clk = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  flush_i = 1'b0;
  logic                  valid_i = 1'b0;
  logic [63:0]           val_i = '0;
  logic [9:0]            commands_i = '0;
  logic [ROBsizeLog-1:0] tag_i = '0;
  logic [3:0]            flags_i = '0;
  logic                  canGo_i = 1'b0;
  logic                  ready_o, valid_o;
  logic [63:0]           val_o;
  logic [9:0]            commands_o;
  logic [ROBsizeLog-1:0] tag_o;
  logic [3:0]            flags_o;
  logic [DEPTHLog:0]     count_o;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [63:0]           val;
    logic [9:0]            cmd;
    logic [ROBsizeLog-1:0] tag;
    logic [3:0]            flg;
  } entry_t;

  entry_t model_q[$];

  exec_result_buffer #(
    .ROBsize(8),
    .ROBsizeLog(ROBsizeLog),
    .DEPTH(DEPTH),
    .DEPTHLog(DEPTHLog)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
`ifdef EXEC_BUF_FLUSH_EN
    .flush_i(flush_i),
`endif
    .valid_i(valid_i),
    .val_i(val_i),
    .commands_i(commands_i),
    .tag_i(tag_i),
    .flags_i(flags_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .val_o(val_o),
    .commands_o(commands_o),
    .tag_o(tag_o),
    .flags_o(flags_o),
    .canGo_i(canGo_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue; full/empty decide whether requests take effect.
  always @(posedge clk) begin
    logic clr, can_push, can_pop;
    clr = reset_i;
`ifdef EXEC_BUF_FLUSH_EN
    clr = clr | flush_i;
`endif
    if (clr) begin
      model_q.delete();
    end else begin
      can_push = valid_i && (model_q.size() < DEPTH);
      can_pop  = canGo_i && (model_q.size() > 0);
      if (can_pop) void'(model_q.pop_front());
      if (can_push) model_q.push_back('{val: val_i, cmd: commands_i, tag: tag_i, flg: flags_i});
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    entry_t h;
    h = (model_q.size() > 0) ? model_q[0] : '0;
    chk("valid_o", 64'(valid_o), 64'(model_q.size() > 0));
    chk("ready_o", 64'(ready_o), 64'(model_q.size() < DEPTH));
    chk("count_o", 64'(count_o), 64'(model_q.size()));
    chk("head",    64'({commands_o, tag_o, flags_o}), 64'({h.cmd, h.tag, h.flg}));
    chk("val_o",   val_o, h.val);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] t);
    valid_i    = v;
    val_i      = d;
    tag_i      = t;
    commands_i = d[9:0] ^ 10'h155;
    flags_i    = d[3:0] ^ t;
  endtask

  initial begin
    int unsigned seed_v;
    // Reset for two cycles
    reset_i = 1'b1;
    cycle();
    cycle();
    reset_i = 1'b0;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_val",   val_o, 64'd0);

    // Single push then grant
    drive(1'b1, 64'hA, 4'd3);
    cycle();
    drive(1'b0, 64'h0, 4'd0);
    chk("t2_valid", 64'(valid_o), 64'd1);
    chk("t2_val",   val_o, 64'hA);
    chk("t2_tag",   64'(tag_o), 64'd3);
    chk("t2_count", 64'(count_o), 64'd1);
    canGo_i = 1'b1;
    cycle();
    canGo_i = 1'b0;
    chk("t2_pop_valid", 64'(valid_o), 64'd0);
    chk("t2_pop_count", 64'(count_o), 64'd0);

    // Fill, back-pressure, release one slot, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 64'(i), 4'(i));
      cycle();
    end
    drive(1'b1, 64'd5, 4'd5);
    chk("t3_full_count", 64'(count_o), 64'd4);
    chk("t3_full_ready", 64'(ready_o), 64'd0);
    cycle();
    chk("t3_held_count", 64'(count_o), 64'd4);
    chk("t3_head1", val_o, 64'd1);
    canGo_i = 1'b1;
    cycle();
    canGo_i = 1'b0;
    chk("t3_after_pop_val",   val_o, 64'd2);
    chk("t3_after_pop_ready", 64'(ready_o), 64'd1);
    chk("t3_after_pop_count", 64'(count_o), 64'd3);
    cycle();
    drive(1'b0, 64'h0, 4'd0);
    chk("t3_accept_count", 64'(count_o), 64'd4);
    for (int i = 2; i <= 5; i++) begin
      chk("t3_drain", val_o, 64'(i));
      canGo_i = 1'b1;
      cycle();
    end
    canGo_i = 1'b0;
    chk("t3_empty", 64'(count_o), 64'd0);

    // Wrap: simultaneous push/pop at occupancy 2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'(10 + i), 4'(i));
      cycle();
    end
    canGo_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("t4_order", val_o, 64'(10 + i));
      drive(1'b1, 64'(12 + i), 4'(i));
      cycle();
      chk("t4_count", 64'(count_o), 64'd2);
    end
    drive(1'b0, 64'h0, 4'd0);
    chk("t4_tail0", val_o, 64'd16);
    cycle();
    chk("t4_tail1", val_o, 64'd17);
    cycle();
    canGo_i = 1'b0;

    // Grant while empty
    canGo_i = 1'b1;
    cycle();
    cycle();
    canGo_i = 1'b0;
    chk("t5_count", 64'(count_o), 64'd0);
    chk("t5_valid", 64'(valid_o), 64'd0);

    // Reset mid-stream with push and pop requested
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(20 + i), 4'(i));
      cycle();
    end
    canGo_i = 1'b1;
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    canGo_i = 1'b0;
    drive(1'b0, 64'h0, 4'd0);
    chk("t6_count", 64'(count_o), 64'd0);
    chk("t6_valid", 64'(valid_o), 64'd0);
    chk("t6_ready", 64'(ready_o), 64'd1);
    chk("t6_val",   val_o, 64'd0);
`ifdef EXEC_BUF_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(30 + i), 4'(i));
      cycle();
    end
    canGo_i = 1'b1;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    canGo_i = 1'b0;
    drive(1'b0, 64'h0, 4'd0);
    chk("t6_flush_count", 64'(count_o), 64'd0);
    chk("t6_flush_valid", 64'(valid_o), 64'd0);
`endif

    // Randomized traffic; the unit holds data while stalled.
    for (int n = 0; n < 3000; n++) begin
      if (!(valid_i && !ready_o)) begin
        seed_v = $urandom_range(99);
        drive(seed_v < 60, {$urandom, $urandom}, 4'($urandom_range(15)));
      end
      canGo_i = ($urandom_range(99) < 45);
      reset_i = ($urandom_range(199) == 0);
`ifdef EXEC_BUF_FLUSH_EN
      flush_i = ($urandom_range(149) == 0);
`endif
      cycle();
    end
    reset_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 64'h0, 4'd0);
    canGo_i = 1'b0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
